// File: rtl/lab1_imul_product_accum.sv
// Sums groups of p_nterms unsigned products into one 33-bit {overflow, sum} result.
// Define LAB1_IMUL_PRODUCT_ACCUM_SAT_EN to saturate the sum instead of wrapping.
module lab1_imul_product_accum #(
    parameter int p_nterms = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [31:0] in_msg,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [32:0] out_msg
);

    localparam int CW = (p_nterms > 1) ? $clog2(p_nterms) : 1;
    localparam logic [CW-1:0] LAST = CW'(p_nterms - 1);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [32:0]   sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        sum     = {1'b0, acc_q} + {1'b0, in_msg};
        unique case (state_q)
            ACC: begin
                if (in_val) begin
`ifdef LAB1_IMUL_PRODUCT_ACCUM_SAT_EN
                    acc_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
`else
                    acc_d = sum[31:0];
`endif
                    ovf_d = ovf_q | sum[32];
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // Result is held until the consumer takes it.
                if (out_rdy) begin
                    state_d = ACC;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    assign in_rdy  = (state_q == ACC);
    assign out_val = (state_q == DONE);
    assign out_msg = {ovf_q, acc_q};

endmodule

// File: tb/tb_lab1_imul_product_accum.sv
// Bench for lab1_imul_product_accum: table vectors, random groups
// against an arithmetic reference, reset and p_nterms=1 sequences.
module tb_lab1_imul_product_accum;

    typedef logic [31:0] grp_t [4];

    typedef struct {
        grp_t        t;
        logic [32:0] ew;
        logic [32:0] es;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [32:0] out_msg;

    logic        p1_in_val;
    logic        p1_in_rdy;
    logic [31:0] p1_in_msg;
    logic        p1_out_val;
    logic        p1_out_rdy;
    logic [32:0] p1_out_msg;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs[7];

    always #5 clk = ~clk;

    lab1_imul_product_accum #(.p_nterms(4)) dut4 (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg)
    );

    lab1_imul_product_accum #(.p_nterms(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .in_val  (p1_in_val),
        .in_rdy  (p1_in_rdy),
        .in_msg  (p1_in_msg),
        .out_val (p1_out_val),
        .out_rdy (p1_out_rdy),
        .out_msg (p1_out_msg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [32:0] act,
                       input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: true integer total; any carry means total >= 2^32.
    function automatic logic [32:0] model(input grp_t t);
        longint unsigned tot;
        logic            ov;
        tot = 0;
        for (int i = 0; i < 4; i++) tot += longint'(t[i]);
        ov = (tot >= 64'h1_0000_0000);
`ifdef LAB1_IMUL_PRODUCT_ACCUM_SAT_EN
        if (ov) return {1'b1, 32'hFFFF_FFFF};
`endif
        return {ov, tot[31:0]};
    endfunction

    function automatic logic [32:0] pick(input vec_t v);
`ifdef LAB1_IMUL_PRODUCT_ACCUM_SAT_EN
        return v.es;
`else
        return v.ew;
`endif
    endfunction

    task automatic set_vec(input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c,
                           input logic [31:0] d, input logic [32:0] ew,
                           input logic [32:0] es);
        vecs[i].t[0] = a;
        vecs[i].t[1] = b;
        vecs[i].t[2] = c;
        vecs[i].t[3] = d;
        vecs[i].ew   = ew;
        vecs[i].es   = es;
    endtask

    task automatic send_group(input string name, input grp_t t,
                              input bit bubbles, input int hold,
                              input bit release_out,
                              input logic [32:0] exp);
        int k;
        int budget;
        k = 0;
        budget = 0;
        while (k < 4 && budget < 200) begin
            in_val  = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_msg  = in_val ? t[k] : $urandom;
            out_rdy = 1'($urandom_range(0, 1));
            if (in_val && in_rdy) k++;
            step();
            budget++;
        end
        in_val  = 1'b0;
        out_rdy = 1'b0;
        if (k < 4) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d terms, expected 4", name, k);
            return;
        end
        chk({name, "_val"}, 33'(out_val), 33'd1);
        chk({name, "_msg"}, out_msg, exp);
        chk({name, "_rdy"}, 33'(in_rdy), 33'd0);
        for (int h = 0; h < hold; h++) begin
            in_val = 1'b1;
            in_msg = $urandom;
            step();
            chk({name, "_hold_val"}, 33'(out_val), 33'd1);
            chk({name, "_hold_msg"}, out_msg, exp);
            chk({name, "_hold_rdy"}, 33'(in_rdy), 33'd0);
        end
        in_val = 1'b0;
        if (release_out) begin
            out_rdy = 1'b1;
            step();
            out_rdy = 1'b0;
            chk({name, "_rel_val"}, 33'(out_val), 33'd0);
            chk({name, "_rel_rdy"}, 33'(in_rdy), 33'd1);
        end
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_rdy"}, 33'(in_rdy), 33'd1);
        chk({name, "_val"}, 33'(out_val), 33'd0);
        chk({name, "_msg"}, out_msg, 33'h0);
    endtask

    initial begin
        grp_t        g;
        logic [31:0] q[$];
        logic [32:0] e;
        bit          exp_rdy;

        set_vec(0, 32'd1, 32'd2, 32'd3, 32'd4, 33'h0_0000000A, 33'h0_0000000A);
        set_vec(1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0,
                33'h1_00000001, 33'h1_FFFFFFFF);
        set_vec(2, 32'd5, 32'd5, 32'd5, 32'd5, 33'h0_00000014, 33'h0_00000014);
        set_vec(3, 32'd0, 32'd0, 32'd0, 32'd0, 33'h0, 33'h0);
        set_vec(4, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0,
                33'h0_FFFFFFFF, 33'h0_FFFFFFFF);
        set_vec(5, 32'h80000000, 32'h80000000, 32'd0, 32'd0,
                33'h1_00000000, 33'h1_FFFFFFFF);
        set_vec(6, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                33'h1_FFFFFFFE, 33'h1_FFFFFFFF);

        reset      = 1'b1;
        in_val     = 1'b0;
        in_msg     = '0;
        out_rdy    = 1'b0;
        p1_in_val  = 1'b0;
        p1_in_msg  = '0;
        p1_out_rdy = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_cleared("reset");
        chk("p1_reset_rdy", 33'(p1_in_rdy), 33'd1);
        chk("p1_reset_msg", p1_out_msg, 33'h0);

        for (int i = 0; i < 7; i++) begin
            send_group($sformatf("vec%0d", i), vecs[i].t, 1'b0,
                       (i == 1) ? 5 : 0, 1'b1, pick(vecs[i]));
        end

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) g[j] = $urandom;
            send_group($sformatf("rnd%0d", i), g, 1'b1,
                       $urandom_range(0, 3), 1'b1, model(g));
        end

        // Partial group 7, 9 discarded by reset; reset beats a transfer.
        in_val = 1'b1;
        in_msg = 32'd7;
        step();
        in_msg = 32'd9;
        step();
        in_msg = 32'd100;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        in_val = 1'b0;
        chk_cleared("rst_mid");
        g = '{32'd1, 32'd1, 32'd1, 32'd1};
        send_group("after_rst", g, 1'b0, 0, 1'b1, 33'h0_00000004);

        // Pending result discarded by reset while in DONE.
        g = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd4};
        send_group("pend", g, 1'b0, 2, 1'b0, model(g));
        reset   = 1'b1;
        out_rdy = 1'b1;
        step();
        reset   = 1'b0;
        out_rdy = 1'b0;
        chk_cleared("rst_done");
        g = '{32'd10, 32'd20, 32'd30, 32'd40};
        send_group("after_rst2", g, 1'b0, 0, 1'b1, 33'h0_00000064);

        p1_in_val  = 1'b1;
        p1_in_msg  = 32'hDEADBEEF;
        p1_out_rdy = 1'b0;
        step();
        p1_in_val = 1'b0;
        chk("p1_val", 33'(p1_out_val), 33'd1);
        chk("p1_msg", p1_out_msg, 33'h0_DEADBEEF);
        chk("p1_rdy", 33'(p1_in_rdy), 33'd0);
        p1_out_rdy = 1'b1;
        step();
        chk("p1_rel_val", 33'(p1_out_val), 33'd0);

        exp_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            p1_in_val = 1'b1;
            p1_in_msg = $urandom;
            chk("p1_alt_rdy", 33'(p1_in_rdy), 33'(exp_rdy));
            chk("p1_alt_val", 33'(p1_out_val), 33'(!exp_rdy));
            if (p1_out_val) begin
                if (q.size() > 0) begin
                    e = {1'b0, q.pop_front()};
                    chk("p1_alt_msg", p1_out_msg, e);
                end else begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL p1_alt_extra: got %h, expected none",
                             p1_out_msg);
                end
            end
            if (p1_in_rdy) q.push_back(p1_in_msg);
            step();
            exp_rdy = !exp_rdy;
        end
        p1_in_val  = 1'b0;
        p1_out_rdy = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
